// File: rtl/coin_change_dispenser_if.sv
// rtl/coin_change_dispenser_if.sv - request, product and change-coin signals of the coin payout block
interface coin_change_dispenser_if #(
  parameter int CREDIT_W = 4
);
  logic                start;
  logic                cancel;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic                product;
  logic [1:0]          coin_out;
  logic                coin_valid;
  logic                coin_ack;
  logic                done;
  logic                err;

  modport master (
    output start, cancel, credit, coin_ack,
    input  busy, product, coin_out, coin_valid, done, err
  );

  modport slave (
    input  start, cancel, credit, coin_ack,
    output busy, product, coin_out, coin_valid, done, err
  );
endinterface

// File: rtl/coin_change_dispenser.sv
// rtl/coin_change_dispenser.sv - releases the product when credit covers the price, then pays change greedily
module coin_change_dispenser #(
  parameter int PRICE    = 3,
  parameter int CREDIT_W = 4
) (
  input logic                    clk,
  input logic                    rst,
  coin_change_dispenser_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_VEND,
    S_PAY,
    S_DONE
  } state_t;

  localparam logic [CREDIT_W-1:0] W_PRICE = CREDIT_W'(PRICE);

  state_t              r_state;
  state_t              w_state_nx;
  logic [CREDIT_W-1:0] r_remaining;
  logic [CREDIT_W-1:0] w_remaining_nx;
  logic                r_cancel;
  logic                w_cancel_nx;
  logic                r_err;
  logic                w_err_nx;
  logic [CREDIT_W-1:0] w_after_vend;
  logic [CREDIT_W-1:0] w_coin_step;
  logic [CREDIT_W-1:0] w_after_coin;

  // Greedy change: a 10c coin whenever two units remain, so at most one 5c coin, always last
  assign w_after_vend = r_remaining - W_PRICE;
  assign w_coin_step  = (r_remaining >= CREDIT_W'(2)) ? CREDIT_W'(2) : CREDIT_W'(1);
  assign w_after_coin = r_remaining - w_coin_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_cancel    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_remaining <= w_remaining_nx;
      r_cancel    <= w_cancel_nx;
      r_err       <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_remaining_nx = r_remaining;
    w_cancel_nx    = r_cancel;
    w_err_nx       = r_err;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_remaining_nx = bus.credit;
          w_cancel_nx    = bus.cancel;
          w_state_nx     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (r_cancel || (r_remaining < W_PRICE)) begin
          w_err_nx   = !r_cancel;
          w_state_nx = (r_remaining != '0) ? S_PAY : S_DONE;
        end else begin
          w_err_nx   = 1'b0;
          w_state_nx = S_VEND;
        end
      end
      S_VEND: begin
        w_remaining_nx = w_after_vend;
        w_state_nx     = (w_after_vend != '0) ? S_PAY : S_DONE;
      end
      S_PAY: begin
        if (bus.coin_ack) begin
          w_remaining_nx = w_after_coin;
          if (w_after_coin == '0) begin
            w_state_nx = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output in the same cycle
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.product    = (r_state == S_VEND);
  assign bus.coin_valid = (r_state == S_PAY);
  assign bus.coin_out   = (r_state != S_PAY) ? 2'b00 :
                          (w_coin_step == CREDIT_W'(2)) ? 2'b10 : 2'b01;
  assign bus.done       = (r_state == S_DONE);
  assign bus.err        = (r_state == S_DONE) && r_err;
endmodule

// File: tb/tb_coin_change_dispenser.sv
// tb/tb_coin_change_dispenser.sv - directed transactions checked cycle by cycle against a timeline model
module tb_coin_change_dispenser;
  localparam int PRICE    = 3;
  localparam int CREDIT_W = 4;

  typedef struct packed {
    logic       busy;
    logic       product;
    logic       cv;
    logic [1:0] code;
    logic       done;
    logic       err;
    logic       ack;
  } ent_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  ent_t tl[$];
  ent_t exp_q[$];

  coin_change_dispenser_if #(.CREDIT_W(CREDIT_W)) bus ();

  coin_change_dispenser #(
    .PRICE   (PRICE),
    .CREDIT_W(CREDIT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ent_t mk(input logic b, input logic p, input logic v,
                              input logic [1:0] c, input logic d, input logic e,
                              input logic a);
    ent_t r;
    r.busy = b; r.product = p; r.cv = v; r.code = c;
    r.done = d; r.err = e; r.ack = a;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Per-cycle timeline of one transaction derived from the pricing and change rules
  task automatic build(input int credit, input bit cancel, input int stall);
    int         change;
    bit         prod;
    logic [1:0] code;
    tl.delete();
    prod   = !cancel && (credit >= PRICE);
    change = prod ? credit - PRICE : credit;
    tl.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0));
    if (prod) tl.push_back(mk(1, 1, 0, 2'b00, 0, 0, 0));
    for (int c = 0; c < (change + 1) / 2; c++) begin
      code = (change - 2 * c >= 2) ? 2'b10 : 2'b01;
      for (int s = 0; s < stall; s++) tl.push_back(mk(1, 0, 1, code, 0, 0, 0));
      tl.push_back(mk(1, 0, 1, code, 0, 0, 1));
    end
    tl.push_back(mk(1, 0, 0, 2'b00, 1, !cancel && (credit < PRICE), 0));
  endtask

  task automatic run(input int credit, input bit cancel, input int stall,
                     input int spur_at, input int abort_at,
                     input int exp_len, input bit exp_err);
    bit aborted;
    build(credit, cancel, stall);
    chk("model_len", tl.size(), exp_len);
    chk("model_err", int'(tl[tl.size()-1].err), int'(exp_err));
    bus.credit = CREDIT_W'(credit);
    bus.cancel = cancel;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.credit = '0;
    foreach (tl[i]) exp_q.push_back(tl[i]);
    aborted = 1'b0;
    for (int k = 0; k < tl.size() && !aborted; k++) begin
      if (k == abort_at) begin
        rst          = 1'b1;
        bus.coin_ack = 1'b0;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst     = 1'b0;
        aborted = 1'b1;
      end else begin
        bus.coin_ack = tl[k].ack;
        if (k == spur_at) begin
          bus.start  = 1'b1;
          bus.credit = '1;
        end else begin
          bus.start  = 1'b0;
          bus.credit = '0;
        end
        @(posedge clk); #1;
      end
    end
    bus.start    = 1'b0;
    bus.credit   = '0;
    bus.coin_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    ent_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(0, 0, 0, 2'b00, 0, 0, 0);
      checks++;
      if ({bus.busy, bus.product, bus.coin_valid, bus.coin_out, bus.done, bus.err} !==
          {e.busy, e.product, e.cv, e.code, e.done, e.err}) begin
        errors++;
        $display("FAIL outputs t=%0t actual busy,prod,cv,coin,done,err=%b required=%b", $time,
                 {bus.busy, bus.product, bus.coin_valid, bus.coin_out, bus.done, bus.err},
                 {e.busy, e.product, e.cv, e.code, e.done, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.cancel   = 1'b0;
    bus.credit   = '0;
    bus.coin_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(3, 0, 0, -1, -1, 3, 0);
    run(6, 0, 0, -1, -1, 5, 0);
    run(2, 0, 0, -1, -1, 3, 1);
    run(5, 1, 4, -1, -1, 17, 0);
    run(9, 0, 0, 3, -1, 6, 0);
    run(3, 0, 0, 2, -1, 3, 0);
    run(9, 0, 0, -1, 3, 6, 0);
    run(3, 0, 0, -1, -1, 3, 0);
    run(0, 1, 0, -1, -1, 2, 0);
    run(0, 0, 0, -1, -1, 2, 1);
    run(1, 0, 2, -1, -1, 5, 1);
    run(15, 0, 1, -1, -1, 15, 0);
    run(4, 1, 0, -1, -1, 4, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
